// File: rtl/ans_ht_ltf_sequencer.sv
// ans_ht_ltf_sequencer
//   Drives the HT-LTF generator through one HT preamble. It issues 1..4 LTF
//   symbols back to back, each with its own obfuscation coefficient, and
//   frames the 80-sample symbols. The samples are forwarded as a
//   valid-qualified stream toward the dot11 TX mux.
//
// Ports
//   clk, rstn        system clock, asynchronous active-low reset
//   start            1-cycle request from the TX controller (sampled in IDLE)
//   num_ltf[2:0]     LTF count, latched at start (0 ignored, >4 clamped to 4)
//   coeff_base[127:0] obfuscation coefficient set, latched at start
//   gen_reset        active-high reset to the generator
//   gen_go           1-cycle letsgo pulse to the generator
//   gen_coeff[127:0] obf_coeff to the generator, held from kick to symbol end
//   gen_sample[31:0] generator sample {I16,Q16}
//   gen_started      generator first-sample flag
//   out_sample[31:0] registered sample to the TX mux
//   out_valid        out_sample qualifier
//   out_last         marks the final sample of the final LTF
//   ltf_idx[1:0]     index of the LTF whose samples are on out_sample
//   busy             high whenever the FSM is not idle
//   done             1-cycle pulse the cycle after out_last
//   err              1-cycle pulse when the generator never starts
//
// Configuration
//   ANS_HT_LTF_SEQ_ROTATE_EN  when defined, each LTF gets coeff_base rotated
//                             left by ltf_idx*COEFF_ROT bits. Otherwise every
//                             LTF gets coeff_base unchanged.

module ans_ht_ltf_sequencer #(
    parameter int SYM_LEN   = 80,
    parameter int GAP_CYC   = 2,
    parameter int TIMEOUT   = 255,
    parameter int COEFF_ROT = 32
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         start,
    input  logic [2:0]   num_ltf,
    input  logic [127:0] coeff_base,
    output logic         gen_reset,
    output logic         gen_go,
    output logic [127:0] gen_coeff,
    input  logic [31:0]  gen_sample,
    input  logic         gen_started,
    output logic [31:0]  out_sample,
    output logic         out_valid,
    output logic         out_last,
    output logic [1:0]   ltf_idx,
    output logic         busy,
    output logic         done,
    output logic         err
);

`ifdef ANS_HT_LTF_SEQ_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif
    // A rotate step of zero makes the rotator a pass-through.
    localparam int ROT_STEP = ROT_EN ? COEFF_ROT : 0;
    localparam int SCNT_W   = $clog2(SYM_LEN);

    typedef enum logic [2:0] {
        S_IDLE, S_GRST, S_GAP, S_KICK, S_WAIT, S_STRM, S_DONE, S_ERR
    } state_t;

    state_t              state, state_nxt;
    logic [7:0]          cnt;       // GAP length, then cycles since gen_go
    logic [SCNT_W-1:0]   scnt;      // sample index within the current symbol
    logic [2:0]          n_ltf;     // clamped LTF count, 1..4
    logic [1:0]          cur_idx;   // LTF the FSM is working on
    logic [127:0]        coeff_q;
    logic [6:0]          rot_amt;
    logic [127:0]        rot_coeff;
    logic                accept, capture, gap_end, sym_end, last_ltf;

    assign accept   = (state == S_IDLE) && start && (num_ltf != 3'd0);
    assign capture  = ((state == S_WAIT) && gen_started) || (state == S_STRM);
    assign gap_end  = (cnt == 8'(GAP_CYC - 1));
    assign sym_end  = (scnt == SCNT_W'(SYM_LEN - 1));
    assign last_ltf = ({1'b0, cur_idx} == (n_ltf - 3'd1));
    assign busy     = (state != S_IDLE);

    // For a zero amount, the right shift by 128 yields zero, so the OR is a pass-through.
    always_comb begin
        rot_amt   = 7'((int'(cur_idx) * ROT_STEP) % 128);
        rot_coeff = (coeff_q << rot_amt) | (coeff_q >> (8'd128 - {1'b0, rot_amt}));
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path through it can leave a value held (which would infer a latch).
    always_comb begin
        state_nxt = state;
        gen_reset = 1'b0;
        gen_go    = 1'b0;
        err       = 1'b0;
        case (state)
            S_IDLE: begin
                gen_reset = 1'b1;
                if (accept) state_nxt = S_GRST;
            end
            S_GRST: begin
                gen_reset = 1'b1;
                state_nxt = S_GAP;
            end
            S_GAP:  if (gap_end) state_nxt = S_KICK;
            S_KICK: begin
                gen_go    = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // A first sample arriving on the timeout cycle still wins.
                if (gen_started)                state_nxt = S_STRM;
                else if (cnt == 8'(TIMEOUT))    state_nxt = S_ERR;
            end
            S_STRM: if (sym_end) state_nxt = last_ltf ? S_DONE : S_GRST;
            S_DONE: begin
                gen_reset = 1'b1;
                state_nxt = S_IDLE;
            end
            S_ERR: begin
                gen_reset = 1'b1;
                err       = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: all registered state uses non-blocking assignments. That way every
    // register samples the pre-edge values of the others, whatever the order
    // of the statements.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            cnt        <= '0;
            scnt       <= '0;
            n_ltf      <= '0;
            cur_idx    <= '0;
            coeff_q    <= '0;
            gen_coeff  <= '0;
            out_sample <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            ltf_idx    <= '0;
            done       <= 1'b0;
        end else begin
            state <= state_nxt;

            // Counts GAP cycles and then restarts at KICK. From there it counts
            // cycles since gen_go, so hitting TIMEOUT in WAIT lands ERR TIMEOUT+1
            // cycles after the kick.
            case (state)
                S_GAP:          cnt <= gap_end ? 8'd0 : cnt + 8'd1;
                S_KICK, S_WAIT: cnt <= cnt + 8'd1;
                default:        cnt <= 8'd0;
            endcase

            // Sample 0 is captured in WAIT, so STRM counts from 1.
            if ((state == S_WAIT) && gen_started)
                scnt <= SCNT_W'(1);
            else if (state == S_STRM)
                scnt <= sym_end ? '0 : scnt + SCNT_W'(1);

            if (accept) begin
                n_ltf   <= (num_ltf > 3'd4) ? 3'd4 : num_ltf;
                coeff_q <= coeff_base;
                cur_idx <= 2'd0;
            end else if ((state == S_STRM) && sym_end && !last_ltf) begin
                cur_idx <= cur_idx + 2'd1;
            end

            // Loaded on the way into KICK, so it is already valid during the gen_go cycle.
            if ((state == S_GAP) && gap_end) gen_coeff <= rot_coeff;

            out_valid <= capture;
            out_last  <= (state == S_STRM) && sym_end && last_ltf;
            if (capture) begin
                out_sample <= gen_sample;
                ltf_idx    <= cur_idx;
            end else if (accept) begin
                ltf_idx    <= 2'd0;
            end

            // Lags DONE by one cycle so it follows the registered out_last.
            done <= (state == S_DONE);
        end
    end

endmodule

// File: tb/tb_ans_ht_ltf_sequencer.sv
`timescale 1ns/1ps
module tb_ans_ht_ltf_sequencer;

    localparam int SYM_LEN   = 80;
    localparam int GAP_CYC   = 2;
    localparam int TIMEOUT   = 255;
    localparam int COEFF_ROT = 32;
`ifdef ANS_HT_LTF_SEQ_ROTATE_EN
    localparam int ROT_STEP = COEFF_ROT;
`else
    localparam int ROT_STEP = 0;
`endif

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   num_ltf = '0;
    logic [127:0] coeff_base = '0;
    logic [31:0]  gen_sample = '0;
    logic         gen_started = 1'b0;
    logic         gen_reset, gen_go, out_valid, out_last, busy, done, err;
    logic [127:0] gen_coeff;
    logic [31:0]  out_sample;
    logic [1:0]   ltf_idx;

    ans_ht_ltf_sequencer #(
        .SYM_LEN(SYM_LEN), .GAP_CYC(GAP_CYC), .TIMEOUT(TIMEOUT), .COEFF_ROT(COEFF_ROT)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .num_ltf(num_ltf), .coeff_base(coeff_base),
        .gen_reset(gen_reset), .gen_go(gen_go), .gen_coeff(gen_coeff),
        .gen_sample(gen_sample), .gen_started(gen_started),
        .out_sample(out_sample), .out_valid(out_valid), .out_last(out_last),
        .ltf_idx(ltf_idx), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] s;
        logic        last;
        logic [1:0]  idx;
    } exp_t;

    exp_t         exp_q[$];
    logic [127:0] coeff_log[$];
    int vectors = 0, miscompares = 0;
    int cyc = 0, start_cyc = 0;
    int go_count, first_go_cyc, done_count, done_cyc, err_count, err_cyc, last_cyc;
    int valid_count, run_count, greset_rises, min_gap, gap_len;
    bit busy_seen, busy_at_last, prev_valid = 1'b0, prev_greset = 1'b1;
    int gen_wait = 0, gen_left = 0, gen_sym = 0, gen_delay = 1, exp_nltf = 0;
    bit gen_enable = 1'b0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference rotation built one bit at a time.
    function automatic logic [127:0] exp_coeff(input logic [127:0] c, input int i);
        logic [127:0] r = c;
        int amt = (i * ROT_STEP) % 128;
        for (int k = 0; k < amt; k++) r = {r[126:0], r[127]};
        return r;
    endfunction

    // One cycle: observe the DUT at the negedge, then act as the generator for the next edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (busy) busy_seen = 1'b1;
        if (gen_go) begin
            if (go_count == 0) first_go_cyc = cyc;
            go_count++;
            coeff_log.push_back(gen_coeff);
        end
        if (done) begin done_count++; done_cyc = cyc; end
        if (err)  begin err_count++;  err_cyc  = cyc; end
        if (gen_reset && !prev_greset && busy) greset_rises++;
        if (out_valid) begin
            if (!prev_valid) begin
                if (run_count > 0 && gap_len < min_gap) min_gap = gap_len;
                run_count++;
            end
            gap_len = 0;
            valid_count++;
            if (out_last) begin last_cyc = cyc; busy_at_last = busy; end
            if (exp_q.size() == 0) begin
                check("unexpected_valid", out_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("out_sample", out_sample, e.s);
                check("out_last", out_last, e.last);
                check("ltf_idx", ltf_idx, e.idx);
            end
        end else begin
            gap_len++;
            if (out_last) check("out_last_idle", out_last, 1'b0);
        end
        prev_valid  = out_valid;
        prev_greset = gen_reset;

        // Generator model: first sample gen_delay cycles after gen_go, then SYM_LEN samples.
        gen_started = 1'b0;
        gen_sample  = $urandom;
        if (gen_wait > 0) begin
            gen_wait--;
            if (gen_wait == 0) begin gen_started = 1'b1; gen_left = SYM_LEN; end
        end
        if (gen_left > 0) begin
            e.s    = gen_sample;
            e.idx  = 2'(gen_sym);
            e.last = (gen_left == 1) && (gen_sym == exp_nltf - 1);
            exp_q.push_back(e);
            gen_left--;
            if (gen_left == 0) gen_sym++;
        end
        if (gen_go && gen_enable) gen_wait = gen_delay;
    endtask

    task automatic launch(input logic [2:0] n, input logic [127:0] c, input int exp_n,
                          input int delay, input bit en);
        go_count = 0; first_go_cyc = -1; done_count = 0; done_cyc = -1;
        err_count = 0; err_cyc = -1; last_cyc = -1; valid_count = 0; run_count = 0;
        greset_rises = 0; min_gap = 1000; gap_len = 0; busy_seen = 1'b0; busy_at_last = 1'b0;
        coeff_log.delete();
        exp_q.delete();
        gen_sym = 0; gen_wait = 0; gen_left = 0;
        exp_nltf = exp_n; gen_delay = delay; gen_enable = en;
        num_ltf = n; coeff_base = c; start = 1'b1;
        start_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        int n = 0;
        while (done_count == 0 && err_count == 0 && n < budget) begin
            tick();
            n++;
        end
        check("end_in_budget", (done_count + err_count) > 0, 1'b1);
    endtask

    task automatic check_run(input int exp_n, input logic [127:0] c);
        check("go_latency", first_go_cyc - start_cyc, 2 + GAP_CYC);
        check("go_count", go_count, exp_n);
        check("valid_count", valid_count, exp_n * SYM_LEN);
        check("run_count", run_count, exp_n);
        check("done_after_last", done_cyc - last_cyc, 1);
        check("done_count", done_count, 1);
        check("busy_at_last", busy_at_last, 1'b1);
        check("err_none", err_count, 0);
        check("queue_drained", exp_q.size(), 0);
        // One gen_reset rise before each follow-on LTF plus one in DONE.
        check("greset_rises", greset_rises, exp_n);
        if (exp_n > 1) check("inter_ltf_gap", min_gap >= 3 + GAP_CYC, 1'b1);
        for (int i = 0; i < coeff_log.size(); i++)
            check("gen_coeff", coeff_log[i], exp_coeff(c, i));
        tick();
        check("busy_after_done", busy, 1'b0);
    endtask

    initial begin : stim
        logic [127:0] c;
        int n;

        // Reset state.
        #12;
        check("rst_gen_reset", gen_reset, 1'b1);
        check("rst_outputs", {gen_go, out_valid, out_last, busy, done, err, ltf_idx}, '0);
        check("rst_data", {out_sample, gen_coeff}, '0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) tick();

        // Single LTF, zero coefficient, generator starts 3 cycles after go.
        launch(3'd1, '0, 1, 3, 1'b1);
        wait_end(600);
        check_run(1, '0);

        // Four LTFs, random coefficient.
        c = {$urandom, $urandom, $urandom, $urandom};
        launch(3'd4, c, 4, 2, 1'b1);
        wait_end(1500);
        check_run(4, c);

        // Coefficient progression across three LTFs.
        launch(3'd3, 128'h1, 3, 5, 1'b1);
        wait_end(1200);
        check_run(3, 128'h1);

        // Generator never starts: timeout.
        launch(3'd1, 128'hABCD, 1, 1, 1'b0);
        wait_end(400);
        check("err_count", err_count, 1);
        check("err_latency", err_cyc - first_go_cyc, TIMEOUT + 1);
        check("timeout_no_valid", valid_count, 0);
        check("timeout_no_done", done_count, 0);
        tick();
        check("idle_after_err", busy, 1'b0);

        // Next start after the error is accepted.
        launch(3'd1, 128'h5, 1, 3, 1'b1);
        wait_end(600);
        check_run(1, 128'h5);

        // num_ltf = 0 is ignored.
        launch(3'd0, 128'h7, 0, 2, 1'b1);
        repeat (10) tick();
        check("zero_ltf_no_go", go_count, 0);
        check("zero_ltf_not_busy", busy_seen, 1'b0);

        // num_ltf = 7 clamps to 4.
        c = {$urandom, $urandom, $urandom, $urandom};
        launch(3'd7, c, 4, 4, 1'b1);
        wait_end(1500);
        check_run(4, c);

        // start in the middle of streaming is ignored.
        c = {$urandom, $urandom, $urandom, $urandom};
        launch(3'd2, c, 2, 4, 1'b1);
        n = 0;
        while (valid_count < 100 && n < 600) begin tick(); n++; end
        check("reach_strm", valid_count >= 100, 1'b1);
        num_ltf    = 3'd1;
        coeff_base = ~c;
        start      = 1'b1;
        tick();
        start = 1'b0;
        wait_end(1000);
        check_run(2, c);
        repeat (10) tick();
        check("no_restart", go_count, 2);

        // Asynchronous reset during sample 40 of LTF 1.
        c = {$urandom, $urandom, $urandom, $urandom};
        launch(3'd2, c, 2, 3, 1'b1);
        n = 0;
        while (valid_count < SYM_LEN + 40 && n < 800) begin tick(); n++; end
        check("reach_ltf1", valid_count >= SYM_LEN + 40, 1'b1);
        rstn = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_gen_reset", gen_reset, 1'b1);
        check("abort_busy", busy, 1'b0);
        gen_left = 0;
        gen_wait = 0;
        exp_q.delete();
        repeat (3) tick();
        rstn = 1'b1;
        repeat (8) tick();
        check("abort_no_done", done_count, 0);
        check("abort_no_err", err_count, 0);
        check("abort_no_kick", go_count, 2);

        // Recovery after reset.
        launch(3'd1, 128'h9, 1, 2, 1'b1);
        wait_end(600);
        check_run(1, 128'h9);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
